// File: rtl/subtractor_16bit_seq.sv
// Multi-cycle 16-bit subtractor: DIFF = A - B - Bin, with borrow out (Bo) and signed overflow (V).
// Processes CHUNK bits per clock through a registered borrow chain, so the carry path spans only
// CHUNK bits. Valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   A, B, Bin            operands, sampled only on the input handshake (in_valid & in_ready)
//   in_valid, in_ready   input handshake; in_ready is a pure decode of the state register
//   DIFF, Bo, V          result registers; change only on the edge that raises out_valid
//   out_valid, out_ready output handshake
module subtractor_16bit_seq #(
  parameter int unsigned CHUNK = 4  // legal: 1, 2, 4, 8, 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] DIFF,
  output logic        Bo,
  output logic        V,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned N     = 16 / CHUNK;
  localparam int unsigned StepW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             state_q, state_d;
  logic [15:0]        a_q, a_d;
  logic [15:0]        b_q, b_d;
  logic [15:0]        wdiff_q, wdiff_d;
  logic               borrow_q, borrow_d;
  logic [StepW-1:0]   step_q, step_d;
  logic [15:0]        diff_q, diff_d;
  logic               bo_q, bo_d;
  logic               v_q, v_d;

  logic [CHUNK-1:0]   a_chunk, b_chunk;
  logic [CHUNK:0]     chunk_res;
  logic [15:0]        wdiff_next;
  logic               last_step;

  // One chunk of the borrow chain. With a zero-extended (CHUNK+1)-bit subtraction the top bit
  // is set exactly when the chunk result went negative, i.e. it is the chunk's borrow out.
  always_comb begin
    a_chunk    = a_q[step_q*CHUNK +: CHUNK];
    b_chunk    = b_q[step_q*CHUNK +: CHUNK];
    chunk_res  = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
    wdiff_next = wdiff_q;
    wdiff_next[step_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
    last_step  = (step_q == StepW'(N - 1));
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    wdiff_d  = wdiff_q;
    borrow_d = borrow_q;
    step_d   = step_q;
    diff_d   = diff_q;
    bo_d     = bo_q;
    v_d      = v_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d      = A;
          b_d      = B;
          borrow_d = Bin;
          step_d   = '0;
          wdiff_d  = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        wdiff_d  = wdiff_next;
        borrow_d = chunk_res[CHUNK];
        step_d   = step_q + StepW'(1);
        if (last_step) begin
          diff_d  = wdiff_next;
          bo_d    = chunk_res[CHUNK];
          // Borrow-in XOR borrow-out of bit 15, expressed through the sign bits: overflow
          // only when operand signs differ and the result sign differs from A.
          v_d     = (a_q[15] ^ b_q[15]) & (wdiff_next[15] ^ a_q[15]);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      wdiff_q  <= '0;
      borrow_q <= 1'b0;
      step_q   <= '0;
      diff_q   <= '0;
      bo_q     <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wdiff_q  <= wdiff_d;
      borrow_q <= borrow_d;
      step_q   <= step_d;
      diff_q   <= diff_d;
      bo_q     <= bo_d;
      v_q      <= v_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign DIFF      = diff_q;
  assign Bo        = bo_q;
  assign V         = v_q;

endmodule

// File: tb/tb_subtractor_16bit_seq.sv
// Self-checking bench: three instances (CHUNK = 4, 1, 16) share one set of inputs. Each has a
// behavioural reference (countdown latency + plain integer arithmetic) checked every cycle,
// plus directed cases with hand-computed literal results and latencies.
module tb_subtractor_16bit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A, B;
  logic        Bin, in_valid, out_ready;

  logic [15:0] diff [3];
  logic        bo [3], v [3], ov [3], ir [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0h exp=%0h t=%0t", nm, g, got, exp, $time);
    end
  endtask

  // Result from the arithmetic definition: {V, Bo, DIFF}.
  function automatic logic [17:0] ref_sub(input logic [15:0] a, input logic [15:0] b,
                                          input logic bin);
    int ua, ub, sa, sb, r;
    logic [15:0] d;
    logic        bor, ovf;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    d   = 16'(ua - ub - int'(bin));
    bor = (ua < ub + int'(bin));
    r   = sa - sb - int'(bin);
    ovf = (r < -32768) || (r > 32767);
    return {ovf, bor, d};
  endfunction

  function automatic int lat(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 16 : 1);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int unsigned C = (g == 0) ? 4 : ((g == 1) ? 1 : 16);

    subtractor_16bit_seq #(.CHUNK(C)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .A        (A),
      .B        (B),
      .Bin      (Bin),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .DIFF     (diff[g]),
      .Bo       (bo[g]),
      .V        (v[g]),
      .out_valid(ov[g]),
      .out_ready(out_ready)
    );

    bit          m_busy, m_valid;
    int          m_cnt;
    logic [15:0] m_a, m_b;
    logic        m_bin;
    logic [17:0] m_res;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
        m_cnt   <= 0;
        m_a     <= '0;
        m_b     <= '0;
        m_bin   <= 1'b0;
        m_res   <= '0;
      end else if (!m_busy && !m_valid) begin
        if (in_valid) begin
          m_a    <= A;
          m_b    <= B;
          m_bin  <= Bin;
          m_cnt  <= 16 / C;
          m_busy <= 1'b1;
        end
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_res   <= ref_sub(m_a, m_b, m_bin);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end

    always @(negedge clk) begin
      chk("in_ready",  g, ir[g], !m_busy && !m_valid);
      chk("out_valid", g, ov[g], m_valid);
      chk("diff",      g, diff[g], m_res[15:0]);
      chk("bo",        g, bo[g], m_res[16]);
      chk("v",         g, v[g], m_res[17]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ir[0] && ir[1] && ir[2]) && n < 50) begin
      out_ready = 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("idle_timeout", 0, ir[0] && ir[1] && ir[2], 1);
  endtask

  // Issue one operation to all idle instances, then check latency and literal results.
  // Leaves every instance in DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] ed, input logic eb, input logic ev);
    int seen [3];
    wait_idle();
    A = a; B = b; Bin = bin; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
    for (int g = 0; g < 3; g++) seen[g] = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      for (int g = 0; g < 3; g++) if (seen[g] < 0 && ov[g]) seen[g] = cyc;
    end
    for (int g = 0; g < 3; g++) begin
      chk("latency",  g, seen[g], lat(g));
      chk("lit_diff", g, diff[g], ed);
      chk("lit_bo",   g, bo[g], eb);
      chk("lit_v",    g, v[g], ev);
    end
  endtask

  initial begin
    rst_n = 1'b0; A = '0; B = '0; Bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_diff", g, diff[g], 16'h0000);
      chk("rst_ir",   g, ir[g], 1);
      chk("rst_ov",   g, ov[g], 0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();

    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    run_op(16'h00FF, 16'h00FF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure in DONE: outputs hold and operands are ignored.
    for (int k = 0; k < 3; k++) begin
      in_valid = ~in_valid;
      A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
      tick();
      for (int g = 0; g < 3; g++) begin
        chk("bp_diff", g, diff[g], 16'hFFFF);
        chk("bp_ov",   g, ov[g], 1);
        chk("bp_ir",   g, ir[g], 0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk("release_ov", g, ov[g], 0);
      chk("release_ir", g, ir[g], 1);
    end

    // Reset two cycles into BUSY aborts the operation.
    A = 16'h4321; B = 16'h1111; Bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("abort_diff", g, diff[g], 16'h0000);
      chk("abort_bo",   g, bo[g], 0);
      chk("abort_ov",   g, ov[g], 0);
      chk("abort_ir",   g, ir[g], 1);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      for (int g = 0; g < 3; g++) chk("abort_no_ov", g, ov[g], 0);
    end
    run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    wait_idle();

    // Random traffic, checked every cycle by the reference processes.
    for (int k = 0; k < 3000; k++) begin
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      Bin       = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       begin A = 16'h8000; B = 16'($urandom_range(0, 3)); end
        1:       begin A = 16'h7FFF; B = 16'hFFFF - 16'($urandom_range(0, 3)); end
        default: begin A = 16'($urandom); B = 16'($urandom); end
      endcase
      tick();
    end
    in_valid = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
